// File: rtl/mux_n_1_rr.sv
// ============================================================================
// Module   : mux_n_1_rr
// Purpose  : N:1 registered mux with valid/ready handshakes, fixed-select or
//            round-robin arbitration. Optional packet lock: MUX_LAST_LOCK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mux_n_1_rr #(
    parameter  int N    = 4,
    parameter  int W    = 8,
    localparam int SELW = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic [SELW-1:0]   sel,
    input  logic [N*W-1:0]    in_data,
    input  logic [N-1:0]      in_valid,
    output logic [N-1:0]      in_ready,
    input  logic [N-1:0]      in_last,
    output logic [W-1:0]      out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SELW-1:0]   out_chan
);

    localparam logic [SELW-1:0] c_last_idx = SELW'(N - 1);
    localparam logic [SELW:0]   c_n        = (SELW + 1)'(N);

    logic [W-1:0]    w_chan_data [N];
    logic            r_out_valid;
    logic [W-1:0]    r_out_data;
    logic [SELW-1:0] r_out_chan;
    logic [SELW-1:0] r_ptr;

    logic            w_load;
    logic            w_fix_valid;
    logic            w_rr_valid;
    logic [SELW:0]   w_rr_sum;
    logic [SELW:0]   w_rr_wrap;
    logic [SELW-1:0] w_rr_chan;
    logic [2*N-1:0]  w_dbl;
    logic            w_grant_valid;
    logic [SELW-1:0] w_grant;
    logic            w_xfer;
    logic [W-1:0]    w_sel_data;
    logic            w_sel_last;
    logic            w_adv;
    logic [SELW-1:0] w_next_ptr;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_unpack
            assign w_chan_data[gi] = in_data[gi*W +: W];
        end
    endgenerate

    assign w_load = ~r_out_valid | out_ready;

    always_comb begin
        w_fix_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (sel == SELW'(i) && in_valid[i]) begin
                w_fix_valid = 1'b1;
            end
        end
    end

    // Rotate the request vector so bit 0 is the channel at ptr; lowest set bit wins.
    assign w_dbl = {in_valid, in_valid} >> r_ptr;

    always_comb begin
        w_rr_valid = 1'b0;
        w_rr_sum   = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (w_dbl[j]) begin
                w_rr_valid = 1'b1;
                w_rr_sum   = {1'b0, r_ptr} + (SELW + 1)'(j);
            end
        end
    end

    assign w_rr_wrap = w_rr_sum - c_n;
    assign w_rr_chan = (w_rr_sum >= c_n) ? w_rr_wrap[SELW-1:0] : w_rr_sum[SELW-1:0];

`ifdef MUX_LAST_LOCK_EN
    logic            r_lock;
    logic [SELW-1:0] r_lock_chan;
    logic            w_lock_valid;

    always_comb begin
        w_lock_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (r_lock_chan == SELW'(i) && in_valid[i]) begin
                w_lock_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock      <= 1'b0;
            r_lock_chan <= '0;
        end else if (w_xfer) begin
            r_lock      <= ~w_sel_last;
            r_lock_chan <= w_grant;
        end
    end
`endif

    always_comb begin
        w_grant_valid = mode ? w_rr_valid : w_fix_valid;
        w_grant       = mode ? w_rr_chan  : sel;
`ifdef MUX_LAST_LOCK_EN
        if (r_lock) begin
            w_grant_valid = w_lock_valid;
            w_grant       = r_lock_chan;
        end
`endif
    end

    assign w_xfer = w_load & w_grant_valid;

    always_comb begin
        in_ready   = '0;
        w_sel_data = '0;
        w_sel_last = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (w_grant == SELW'(i)) begin
                in_ready[i] = w_xfer;
                w_sel_data  = w_chan_data[i];
                w_sel_last  = in_last[i];
            end
        end
    end

`ifdef MUX_LAST_LOCK_EN
    assign w_adv = mode & w_sel_last;
`else
    logic w_unused_last;
    assign w_unused_last = w_sel_last;
    assign w_adv         = mode;
`endif

    assign w_next_ptr = (w_grant == c_last_idx) ? '0 : w_grant + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_ptr       <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sel_data;
            r_out_chan  <= w_grant;
            if (w_adv) begin
                r_ptr <= w_next_ptr;
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;

endmodule

`default_nettype wire

// File: tb/tb_mux_n_1_rr.sv
// ============================================================================
// Module   : tb_mux_n_1_rr
// Purpose  : Vector table, directed corner sequences and randomized traffic
//            against a behavioural model of mux_n_1_rr (N=4, W=8).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mux_n_1_rr;

    localparam int N = 4;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         mode;
    logic [1:0]   sel;
    logic [31:0]  in_data;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [3:0]   in_last;
    logic [7:0]   out_data;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   out_chan;

    mux_n_1_rr #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_chan  (out_chan)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model state
    int         m_ptr;
    int         m_lock;
    logic [1:0] m_lchan;
    logic       m_ov;
    logic [7:0] m_od;
    int         m_oc;
    int         last_g;

    function automatic void model_reset();
        m_ptr = 0; m_lock = 0; m_lchan = 2'd0;
        m_ov = 1'b0; m_od = 8'h00; m_oc = 0;
    endfunction

    function automatic int pick();
        int order[$];
        if (m_lock != 0) return in_valid[m_lchan] ? int'(m_lchan) : -1;
        if (!mode) return in_valid[sel] ? int'(sel) : -1;
        for (int k = 0; k < N; k++) order.push_back((m_ptr + k) % N);
        foreach (order[q]) begin
            if (in_valid[2'(order[q])]) return order[q];
        end
        return -1;
    endfunction

    task automatic cycle(output logic [3:0] rdy);
        int         g;
        logic       load;
        logic [3:0] exp_rdy;
        @(negedge clk);
        g       = pick();
        load    = !m_ov || out_ready;
        exp_rdy = (load && g >= 0) ? 4'(1 << g) : 4'b0000;
        rdy     = in_ready;
        chk("in_ready", {28'b0, in_ready}, {28'b0, exp_rdy});
        @(posedge clk);
        #1;
        last_g = -1;
        if (load && g >= 0) begin
            last_g = g;
            m_ov   = 1'b1;
            m_od   = in_data[g*W +: W];
            m_oc   = g;
`ifdef MUX_LAST_LOCK_EN
            if (mode && in_last[2'(g)]) m_ptr = (g + 1) % N;
            m_lock  = in_last[2'(g)] ? 0 : 1;
            m_lchan = 2'(g);
`else
            if (mode) m_ptr = (g + 1) % N;
`endif
        end else if (out_ready) begin
            m_ov = 1'b0;
        end
        chk("out_valid", {31'b0, out_valid}, {31'b0, m_ov});
        chk("out_chan", {30'b0, out_chan}, 32'(m_oc));
        chk("out_data", {24'b0, out_data}, {24'b0, m_od});
    endtask

    task automatic do_reset();
        in_valid = 4'b0000;
        rst_n    = 1'b0;
        #3;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       mode;
        logic [1:0] sel;
        logic [3:0] valid;
        logic       ready;
        logic [3:0] rdy;
        logic       ov;
        logic [1:0] chan;
    } vec_t;

    vec_t       tbl [24];
    logic [3:0] rdy;
    logic [1:0] lock_exp [4];
    int         ch0_sent;

    initial begin
        // mode sel valid ready | in_ready out_valid out_chan
        tbl[0]  = '{1'b0, 2'd2, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2};
        tbl[1]  = '{1'b0, 2'd2, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2};
        tbl[2]  = '{1'b0, 2'd1, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[3]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[4]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[5]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2};
        tbl[6]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b1000, 1'b1, 2'd3};
        tbl[7]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[8]  = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[9]  = '{1'b1, 2'd0, 4'hA, 1'b1, 4'b1000, 1'b1, 2'd3};
        tbl[10] = '{1'b1, 2'd0, 4'hA, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[11] = '{1'b1, 2'd0, 4'hA, 1'b1, 4'b1000, 1'b1, 2'd3};
        tbl[12] = '{1'b1, 2'd0, 4'hA, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[13] = '{1'b1, 2'd0, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd1};
        tbl[14] = '{1'b1, 2'd0, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd1};
        tbl[15] = '{1'b1, 2'd0, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd1};
        tbl[16] = '{1'b1, 2'd0, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2};
        tbl[17] = '{1'b1, 2'd0, 4'h0, 1'b1, 4'b0000, 1'b0, 2'd2};
        tbl[18] = '{1'b1, 2'd0, 4'h0, 1'b1, 4'b0000, 1'b0, 2'd2};
        tbl[19] = '{1'b1, 2'd0, 4'h0, 1'b1, 4'b0000, 1'b0, 2'd2};
        tbl[20] = '{1'b1, 2'd0, 4'h0, 1'b1, 4'b0000, 1'b0, 2'd2};
        tbl[21] = '{1'b1, 2'd0, 4'h0, 1'b1, 4'b0000, 1'b0, 2'd2};
        tbl[22] = '{1'b1, 2'd0, 4'h8, 1'b1, 4'b1000, 1'b1, 2'd3};
        tbl[23] = '{1'b0, 2'd3, 4'h7, 1'b1, 4'b0000, 1'b0, 2'd3};

        rst_n     = 1'b0;
        mode      = 1'b0;
        sel       = 2'd0;
        in_data   = 32'h44332211;
        in_valid  = 4'b0000;
        in_last   = 4'b1111;
        out_ready = 1'b1;
        model_reset();

        @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data", {24'b0, out_data}, 32'd0);
        chk("rst_out_chan", {30'b0, out_chan}, 32'd0);
        chk("rst_in_ready", {28'b0, in_ready}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int r = 0; r < 24; r++) begin
            mode      = tbl[r].mode;
            sel       = tbl[r].sel;
            in_valid  = tbl[r].valid;
            out_ready = tbl[r].ready;
            cycle(rdy);
            chk("tbl_in_ready", {28'b0, rdy}, {28'b0, tbl[r].rdy});
            chk("tbl_out_valid", {31'b0, out_valid}, {31'b0, tbl[r].ov});
            chk("tbl_out_chan", {30'b0, out_chan}, {30'b0, tbl[r].chan});
            chk("tbl_out_data", {24'b0, out_data}, 32'((32'(tbl[r].chan) + 1) * 32'h11));
        end

        // Asynchronous reset while a beat is held
        mode = 1'b1; in_valid = 4'hF; out_ready = 1'b0;
        cycle(rdy);
        chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("async_rst_data", {24'b0, out_data}, 32'd0);
        chk("async_rst_chan", {30'b0, out_chan}, 32'd0);
        model_reset();
        in_valid = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 4'hF; out_ready = 1'b1;
        cycle(rdy);
        chk("post_rst_first_grant", {30'b0, out_chan}, 32'd0);

        // Packet sequence: channel 0 sends three beats, last flagged on the third
`ifdef MUX_LAST_LOCK_EN
        lock_exp = '{2'd0, 2'd0, 2'd0, 2'd2};
`else
        lock_exp = '{2'd0, 2'd2, 2'd0, 2'd2};
`endif
        do_reset();
        mode = 1'b1; out_ready = 1'b1; in_valid = 4'b0101; in_data = 32'h44332211;
        ch0_sent = 0;
        for (int i = 0; i < 4; i++) begin
            in_last = {3'b111, (ch0_sent == 2)};
            cycle(rdy);
            chk("pkt_seq_chan", {30'b0, out_chan}, {30'b0, lock_exp[i]});
            if (last_g == 0) ch0_sent++;
        end

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            mode      = 1'($urandom_range(0, 1));
            sel       = 2'($urandom_range(0, 3));
            in_valid  = 4'($urandom);
            in_last   = 4'($urandom);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            cycle(rdy);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
